// File: rtl/prefetch_pkg.sv
// Shared types for the instruction prefetch unit: FSM state and FIFO entry.
// No logic, no latency.
// No flow control of its own.
package prefetch_pkg;

    // Field widths of a FIFO entry; the top-level ADDR_WIDTH/DATA_WIDTH must match.
    localparam int PF_ADDR_WIDTH = 8;
    localparam int PF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        WAIT_RV    = 2'd2,
        WAIT_ABORT = 2'd3
    } prefetch_state_e;

    typedef struct packed {
        logic [PF_DATA_WIDTH-1:0] rdata;
        logic [PF_ADDR_WIDTH-1:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small circular FIFO holding fetched instructions, head read straight from registers.
// Latency: a push at edge N is visible at the head in cycle N+1.
// Backpressure: no internal refusal; the producer reserves a slot before pushing, flush wins over push.
module prefetch_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [7:0]
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  entry_t                     i_push_dat,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_head_vld,
    output entry_t                     o_head_dat
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop;

    // A pop on an empty FIFO is ignored so the count can never underflow.
    assign w_pop = i_pop && (r_count != '0);

    // Entry storage: cleared on reset so the head outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count    = r_count;
    assign o_head_vld = (r_count != '0);
    assign o_head_dat = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_prefetch_unit.sv
// Sequential instruction fetcher: one memory transaction at a time into a small FIFO, redirectable by branches.
// Latency: rvalid at edge N gives instr_valid_o in cycle N+1; a request starts the cycle after IDLE sees a free slot.
// Backpressure: a request only starts when count + outstanding < DEPTH, so a stalled decode stops fetching.
module instr_prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH = PF_ADDR_WIDTH,
    parameter int DATA_WIDTH = PF_DATA_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] boot_addr_i,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  busy_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int                    STEP     = DATA_WIDTH / 8;
    localparam int                    CNT_W    = $clog2(DEPTH+1);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(STEP - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP_A   = ADDR_WIDTH'(STEP);
    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);

    prefetch_state_e       r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_addr;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic                  r_pend_vld;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;

    logic [CNT_W-1:0]      w_count;
    logic                  w_head_vld;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_slot_free;
    logic [ADDR_WIDTH-1:0] w_branch_tgt;
    logic [ADDR_WIDTH-1:0] w_pend_tgt;
    fetch_entry_t          w_push_dat;
    fetch_entry_t          w_head_dat;

    assign w_branch_tgt = branch_addr_i & ~LOW_MASK;
    // The newest redirect wins: a branch this cycle overrides an older pending target.
    assign w_pend_tgt   = branch_i ? w_branch_tgt : r_pend_addr;
    // Only checked in IDLE, where nothing is outstanding.
    assign w_slot_free  = (w_count < DEPTH_C);
    // A response arriving together with a branch is stale and is dropped.
    assign w_push       = (r_state == WAIT_RV) && mem_rvalid_i && !branch_i;
    assign w_pop        = w_head_vld && instr_ready_i;
    assign w_push_dat   = '{rdata: mem_rdata_i, addr: r_fetch_addr};

    prefetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (branch_i),
        .o_count    (w_count),
        .o_head_vld (w_head_vld),
        .o_head_dat (w_head_dat)
    );

    // Fetch FSM: address generation, memory handshake and branch redirect bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_fetch_addr <= boot_addr_i & ~LOW_MASK;
            r_pend_addr  <= '0;
            r_pend_vld   <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (branch_i) begin
                        r_fetch_addr <= w_branch_tgt;
                    end else if (w_slot_free) begin
                        r_state    <= REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_addr;
                    end
                end
                REQ: begin
                    // The request stays up until granted, even across a redirect.
                    if (branch_i) begin
                        r_pend_vld  <= 1'b1;
                        r_pend_addr <= w_branch_tgt;
                    end
                    if (mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= (branch_i || r_pend_vld) ? WAIT_ABORT : WAIT_RV;
                    end
                end
                WAIT_RV: begin
                    if (mem_rvalid_i) begin
                        r_state      <= IDLE;
                        r_fetch_addr <= branch_i ? w_branch_tgt : r_fetch_addr + STEP_A;
                    end else if (branch_i) begin
                        r_state     <= WAIT_ABORT;
                        r_pend_vld  <= 1'b1;
                        r_pend_addr <= w_branch_tgt;
                    end
                end
                WAIT_ABORT: begin
                    if (mem_rvalid_i) begin
                        r_state      <= IDLE;
                        r_fetch_addr <= w_pend_tgt;
                        r_pend_vld   <= 1'b0;
                    end else if (branch_i) begin
                        r_pend_addr <= w_branch_tgt;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_o     = r_mem_req;
    assign mem_addr_o    = r_mem_addr;
    assign instr_valid_o = w_head_vld;
    assign instr_rdata_o = w_head_dat.rdata;
    assign instr_addr_o  = w_head_dat.addr;
    assign busy_o        = (r_state != IDLE) || (w_count != '0);

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with a req/gnt/rvalid memory model.
// Memory model: grant two cycles after req is first seen, data two cycles after grant.
// Decode-side ready is driven per test to exercise flow and backpressure.
module tb_instr_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  boot_addr_i = 8'h00;
    logic        branch_i = 1'b0;
    logic [7:0]  branch_addr_i = 8'h00;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_rdata_o;
    logic [7:0]  instr_addr_o;
    logic        busy_o;
    logic        mem_req_o;
    logic [7:0]  mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instr_prefetch_unit #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .DEPTH      (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .boot_addr_i   (boot_addr_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_rdata_o (instr_rdata_o),
        .instr_addr_o  (instr_addr_o),
        .busy_o        (busy_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    // Memory contents
    function automatic logic [31:0] mem_word(input logic [7:0] a);
        case (a)
            8'h00:   return 32'h10000113;
            8'h04:   return 32'h00100093;
            8'h80:   return 32'hF81FF06F;
            default: return 32'hA5A5_0000 | {24'h0, a};
        endcase
    endfunction

    // Memory model state
    int         greq = 0;
    int         dcnt = 0;
    bit         dpend = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] daddr = 8'h00;
    int         n_gnt = 0;
    int         stab_err = 0;

    always @(negedge clk) begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        if (dpend) begin
            dcnt--;
            if (dcnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_word(daddr);
                dpend        = 1'b0;
            end
        end
        if (rst) begin
            greq = 0;
        end else if (mem_req_o) begin
            if (greq == 0) held = mem_addr_o;
            else if (mem_addr_o != held) stab_err++;
            greq++;
            if (greq == 3) begin
                mem_gnt_i = 1'b1;
                greq      = 0;
                dpend     = 1'b1;
                dcnt      = 2;
                daddr     = mem_addr_o;
                n_gnt++;
            end
        end else if (greq != 0) begin
            stab_err++;
            greq = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_vld"},   instr_valid_o, 0);
        chk({tag, "_req"},   mem_req_o,     0);
        chk({tag, "_busy"},  busy_o,        0);
        chk({tag, "_maddr"}, mem_addr_o,    0);
        chk({tag, "_rdata"}, instr_rdata_o, 0);
        chk({tag, "_iaddr"}, instr_addr_o,  0);
    endtask

    task automatic do_reset(input logic [7:0] boot, input logic rdy, input string tag);
        @(negedge clk);
        rst = 1'b1; boot_addr_i = boot; instr_ready_i = rdy; branch_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs(tag);
        rst = 1'b0;
    endtask

    // Called at a negedge; waits for a head entry, checks it, then moves one negedge on.
    task automatic expect_instr(input string tag, input logic [7:0] ea, input logic [31:0] ed);
        int n = 0;
        while (!instr_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"},  instr_valid_o, 1);
        chk({tag, "_addr"}, instr_addr_o,  ea);
        chk({tag, "_data"}, instr_rdata_o, ed);
        @(negedge clk);
    endtask

    task automatic wait_grant(output logic found, output logic [7:0] addr);
        found = 1'b0;
        addr  = 8'h00;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            if (mem_gnt_i) begin
                found = 1'b1;
                addr  = mem_addr_o;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       found;
        logic [7:0] gaddr;
        int         base;

        // Boot from 0x00 with decode always ready
        do_reset(8'h00, 1'b1, "rst_boot");
        expect_instr("boot0", 8'h00, 32'h10000113);
        expect_instr("boot1", 8'h04, 32'h00100093);
        chk("boot_addr_stable", stab_err, 0);

        // Backpressure: two requests fill the FIFO, then fetching stops
        do_reset(8'h00, 1'b0, "rst_bp");
        base = n_gnt;
        repeat (30) @(negedge clk);
        chk("bp_head_addr_a", instr_addr_o,  8'h00);
        chk("bp_head_data_a", instr_rdata_o, 32'h10000113);
        repeat (30) @(negedge clk);
        chk("bp_req_count", n_gnt - base, 2);
        chk("bp_req_low",   mem_req_o,    0);
        chk("bp_busy",      busy_o,       1);
        chk("bp_head_addr_b", instr_addr_o,  8'h00);
        chk("bp_head_data_b", instr_rdata_o, 32'h10000113);
        instr_ready_i = 1'b1;
        expect_instr("bp0", 8'h00, 32'h10000113);
        expect_instr("bp1", 8'h04, 32'h00100093);
        expect_instr("bp2", 8'h08, 32'hA5A50008);

        // Branch while IDLE with a full FIFO
        do_reset(8'h00, 1'b0, "rst_bri");
        repeat (40) @(negedge clk);
        chk("bri_pre_vld", instr_valid_o, 1);
        branch_i = 1'b1; branch_addr_i = 8'h80;
        @(negedge clk);
        branch_i = 1'b0;
        chk("bri_flush_vld", instr_valid_o, 0);
        chk("bri_flush_busy", busy_o, 0);
        wait_grant(found, gaddr);
        chk("bri_gnt_found", found, 1);
        chk("bri_gnt_addr", gaddr, 8'h80);
        expect_instr("bri", 8'h80, 32'hF81FF06F);

        // Branch while waiting for read data: in-flight response dropped
        do_reset(8'h00, 1'b0, "rst_brw");
        wait_grant(found, gaddr);
        chk("brw_first_addr", gaddr, 8'h00);
        branch_i = 1'b1; branch_addr_i = 8'h29;
        @(negedge clk);
        branch_i = 1'b0;
        @(negedge clk);
        chk("brw_drop_vld", instr_valid_o, 0);
        wait_grant(found, gaddr);
        chk("brw_gnt_found", found, 1);
        chk("brw_gnt_addr", gaddr, 8'h28);
        expect_instr("brw", 8'h28, 32'hA5A50028);

        // Address wrap from 0xFC to 0x00
        do_reset(8'hFC, 1'b1, "rst_wrap");
        expect_instr("wrap0", 8'hFC, 32'hA5A500FC);
        expect_instr("wrap1", 8'h00, 32'h10000113);

        // Reset during WAIT_RV; the late rvalid lands in IDLE and is ignored
        wait_grant(found, gaddr);
        chk("rmid_gnt_found", found, 1);
        rst = 1'b1; boot_addr_i = 8'h40; instr_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_zero_outputs("rmid");
        @(negedge clk);
        chk("rmid_stale_vld", instr_valid_o, 0);
        chk("rmid_req", mem_req_o, 1);
        wait_grant(found, gaddr);
        chk("rmid_gnt_addr", gaddr, 8'h40);
        expect_instr("rmid", 8'h40, 32'hA5A50040);

        chk("addr_stable_all", stab_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
- Fetch stage directly upstream of `instruction_memory`. It generates sequential fetch addresses and drives the memory's req/gnt/rvalid handshake, one transaction outstanding at a time.
- Fetched words go into a small FIFO. Each word is presented to the decode stage with its address under valid/ready.
- Handles branch redirects: flushes the FIFO and drops the in-flight response.

Parameters:
- ADDR_WIDTH, 8, byte-address width; must match the memory's ADDR_WIDTH.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- boot_addr_i  in  ADDR_WIDTH  fetch start address, sampled while rst=1.
- branch_i  in  1  one-cycle redirect strobe.
- branch_addr_i  in  ADDR_WIDTH  redirect target, sampled when branch_i=1.
- instr_valid_o  out  1  FIFO head valid.
- instr_ready_i  in  1  decode accepts the head.
- instr_rdata_o  out  DATA_WIDTH  head instruction.
- instr_addr_o  out  ADDR_WIDTH  byte address of the head instruction.
- busy_o  out  1  transaction outstanding or FIFO non-empty.
- mem_req_o  out  1  memory request.
- mem_addr_o  out  ADDR_WIDTH  memory byte address.
- mem_gnt_i  in  1  grant from memory.
- mem_rvalid_i  in  1  read data valid from memory.
- mem_rdata_i  in  DATA_WIDTH  read data from memory.

Behaviour:
- Reset (rst=1 at an edge):
  - All outputs are 0; FIFO is empty; state is IDLE.
  - fetch_addr is loaded with boot_addr_i with its low log2(DATA_WIDTH/8) bits cleared.
  - Reset mid-transaction abandons the transaction. After reset, any rvalid pulse arriving while in IDLE is ignored.
- Word step: STEP = DATA_WIDTH/8. fetch_addr increments by STEP modulo 2^ADDR_WIDTH (0xFC wraps to 0x00 at defaults).
- Slot reservation: a request may start only if count + outstanding < DEPTH, so an arriving response always has a free slot.
- FSM states: IDLE, REQ, WAIT_RV, WAIT_ABORT.
  - IDLE: when a slot is free and no branch is present, go to REQ. mem_req_o rises the cycle after entry, so the first req is the first cycle after rst falls.
  - REQ: mem_req_o=1 and mem_addr_o=fetch_addr, both held stable until the cycle with mem_gnt_i=1. The request is never withdrawn. On gnt, go to WAIT_RV, or to WAIT_ABORT if a branch is pending.
  - WAIT_RV: mem_req_o=0. On mem_rvalid_i:
    - push {mem_rdata_i, fetch_addr} into the FIFO;
    - fetch_addr += STEP;
    - go to IDLE.
  - WAIT_ABORT: on mem_rvalid_i, discard the data, load fetch_addr with the pending branch address, and go to IDLE.
- Branch, in any state:
  - FIFO is cleared at that edge; instr_valid_o=0 from the next cycle.
  - In IDLE: fetch_addr is loaded with the aligned branch_addr_i.
  - In REQ, WAIT_RV or WAIT_ABORT: the aligned target is stored as pending, and fetch_addr is loaded from it once the current transaction completes.
  - A later branch before completion overwrites the pending target; last branch wins.
  - Branch in the same cycle as rvalid: the response is dropped and the branch target is used.
- FIFO:
  - Head is registered. Push at edge N gives instr_valid_o=1 in cycle N+1 (one-cycle rvalid-to-valid latency).
  - A pop happens when instr_valid_o && instr_ready_i.
  - Simultaneous push and pop is legal at any count.
  - instr_rdata_o and instr_addr_o are held stable while valid && !ready.
  - Pointers wrap modulo DEPTH.
- busy_o = (state != IDLE) || (count != 0).

Decomposition:
- Package `prefetch_pkg`: the state enum typedef `prefetch_state_e` (IDLE, REQ, WAIT_RV, WAIT_ABORT) and a struct `fetch_entry_t` {rdata, addr}.
- One sub-module: `prefetch_fifo`, parameterised by DEPTH and entry type. It provides push, pop, flush, count, and head outputs. The FSM and address logic stay in the top module.

Test Plan:
- Boot from boot_addr_i=0x00 against the memory model (2-cycle grant delay, 2-cycle data delay), ready held 1 → instr 0x10000113 with addr 0x00, then 0x00100093 with addr 0x04, in order; mem_addr_o never changes while req is high and gnt is low.
- Backpressure: ready=0 with DEPTH=2 → exactly 2 requests issued, then mem_req_o stays 0; head holds 0x10000113 at addr 0x00; raising ready resumes fetching at 0x08.
- Branch in IDLE to 0x80 → FIFO flushed, next mem_addr_o=0x80, head becomes 0xF81FF06F with addr 0x80.
- Branch while in WAIT_RV to 0x29 → in-flight response dropped; next request at 0x28 (aligned); no instruction from the aborted address ever appears.
- Wrap: boot_addr_i=0xFC → fetches are issued at 0xFC then 0x00.
- Reset asserted during WAIT_RV, then memory rvalid arrives → all outputs 0, the stale response is ignored, and the first new request is at boot_addr_i.
